// File: rtl/usb_tx.sv
// USB full/low-speed bit-level transmitter.
// Takes bytes from the SIE over a valid/ready handshake and serialises each
// packet as SYNC, LSB-first data with bit stuffing and NRZI, then EOP.
// Ports:
//   clk     - system clock
//   reset   - asynchronous active-low reset
//   clk_en  - bit-rate enable, one clk cycle per bit period
//   data    - byte from SIE, held while valid=1 until ready
//   valid   - SIE has a byte; held high for the whole packet
//   ready   - one-clk pulse: byte on data consumed this cycle
//   d_o     - line state when se0=0 (0 = J, 1 = K)
//   se0     - drive SE0
//   oe      - transmitter output enable
//   active  - high from SYNC start until the EOP J bit completes
module usb_tx #(
    parameter int unsigned EOP_SE0_BITS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clk_en,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       d_o,
    output logic       se0,
    output logic       oe,
    output logic       active
);

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned EOP_W   = 2;
    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] SYNC    = 3'd1;
    localparam logic [STATE_W-1:0] DATA    = 3'd2;
    localparam logic [STATE_W-1:0] STUFF   = 3'd3;
    localparam logic [STATE_W-1:0] EOP_SE0 = 3'd4;
    localparam logic [STATE_W-1:0] EOP_J   = 3'd5;

    localparam logic [CNT_W-1:0] LAST_BIT  = 3'd7;
    localparam logic [CNT_W-1:0] STUFF_RUN = 3'd6;
    localparam logic [EOP_W-1:0] EOP_LAST  = EOP_W'(EOP_SE0_BITS - 1);

    logic [STATE_W-1:0] state,     state_n;
    logic [CNT_W-1:0]   bit_cnt,   bit_cnt_n;   // index of the bit on the line
    logic [BYTE_W-1:0]  shift,     shift_n;     // shift[0] is the bit on the line
    logic [CNT_W-1:0]   stuff_cnt, stuff_cnt_n; // ones emitted in a row, incl. current
    logic [EOP_W-1:0]   eop_cnt,   eop_cnt_n;
    logic               d_o_n, se0_n, oe_n, active_n;
    logic               emit_c, bit_c;
    logic               load_point_c;

    // Byte boundary reached with no stuff bit still owed.
    assign load_point_c = (((state == SYNC) || (state == DATA)) &&
                           (bit_cnt == LAST_BIT) && (stuff_cnt != STUFF_RUN)) ||
                          ((state == STUFF) && (bit_cnt == LAST_BIT));

    assign ready = clk_en & valid & load_point_c;

    // Registered state and line outputs, advanced once per bit period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            stuff_cnt <= '0;
            eop_cnt   <= '0;
            d_o       <= 1'b0;
            se0       <= 1'b0;
            oe        <= 1'b0;
            active    <= 1'b0;
        end else if (clk_en) begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shift     <= shift_n;
            stuff_cnt <= stuff_cnt_n;
            eop_cnt   <= eop_cnt_n;
            d_o       <= d_o_n;
            se0       <= se0_n;
            oe        <= oe_n;
            active    <= active_n;
        end
    end

    // Next-state and next-symbol decode for the following bit period.
    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift;
        stuff_cnt_n = stuff_cnt;
        eop_cnt_n   = eop_cnt;
        d_o_n       = d_o;
        se0_n       = se0;
        oe_n        = oe;
        active_n    = active;
        emit_c      = 1'b0;
        bit_c       = 1'b0;

        case (state)
            IDLE: begin
                d_o_n       = 1'b0;
                se0_n       = 1'b0;
                oe_n        = 1'b0;
                active_n    = 1'b0;
                stuff_cnt_n = '0;
                bit_cnt_n   = '0;
                if (valid) begin
                    state_n  = SYNC;
                    oe_n     = 1'b1;
                    active_n = 1'b1;
                    emit_c   = 1'b1;
                    bit_c    = 1'b0;
                end
            end
            SYNC, DATA, STUFF: begin
                if ((state != STUFF) && (stuff_cnt == STUFF_RUN)) begin
                    // Stuff bit: a zero, bit position and shifter hold.
                    state_n = STUFF;
                    emit_c  = 1'b1;
                    bit_c   = 1'b0;
                end else if (bit_cnt == LAST_BIT) begin
                    if (valid) begin
                        state_n   = DATA;
                        shift_n   = data;
                        bit_cnt_n = '0;
                        emit_c    = 1'b1;
                        bit_c     = data[0];
                    end else begin
                        state_n   = EOP_SE0;
                        eop_cnt_n = '0;
                        se0_n     = 1'b1;
                        d_o_n     = 1'b0;
                    end
                end else begin
                    bit_cnt_n = CNT_W'(bit_cnt + 3'd1);
                    emit_c    = 1'b1;
                    if (state == SYNC) begin
                        // SYNC is seven zeros followed by a single one.
                        bit_c = (bit_cnt == 3'd6);
                    end else begin
                        state_n = DATA;
                        shift_n = shift >> 1;
                        bit_c   = shift[1];
                    end
                end
            end
            EOP_SE0: begin
                d_o_n = 1'b0;
                if (eop_cnt == EOP_LAST) begin
                    state_n = EOP_J;
                    se0_n   = 1'b0;
                end else begin
                    eop_cnt_n = EOP_W'(eop_cnt + 2'd1);
                end
            end
            EOP_J: begin
                state_n  = IDLE;
                d_o_n    = 1'b0;
                se0_n    = 1'b0;
                oe_n     = 1'b0;
                active_n = 1'b0;
            end
            default: begin
                state_n  = IDLE;
                d_o_n    = 1'b0;
                se0_n    = 1'b0;
                oe_n     = 1'b0;
                active_n = 1'b0;
            end
        endcase

        // NRZI: a zero toggles the line, a one holds it.
        if (emit_c) begin
            d_o_n       = bit_c ? d_o : ~d_o;
            stuff_cnt_n = bit_c ? CNT_W'(stuff_cnt + 3'd1) : '0;
        end
    end

endmodule

// File: tb/tb_usb_tx.sv
// Self-checking bench for usb_tx: directed and random packets compared
// symbol by symbol against a bit-stream reference model.
module tb_usb_tx;

    localparam int EOP = 2;

    logic       clk;
    logic       reset;
    logic       clk_en;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       d_o;
    logic       se0;
    logic       oe;
    logic       active;

    int checks = 0;
    int errors = 0;
    int en_ph  = 0;

    logic [7:0] pkt[$];

    usb_tx #(.EOP_SE0_BITS(EOP)) dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .data   (data),
        .valid  (valid),
        .ready  (ready),
        .d_o    (d_o),
        .se0    (se0),
        .oe     (oe),
        .active (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Sends pkt with clk_en every div-th cycle; optionally resets once
    // symbol abort_at is on the line.
    task automatic send(input int div, input int abort_at);
        bit raw[$];
        bit stf[$];
        bit exp_d[$];
        bit exp_s[$];
        bit exp_r[$];
        int n, ones, nsym, j, k, rdy_seen, budget;
        bit lvl, rdy_now, en_now;

        // Reference: raw bits, then stuffing, then NRZI and EOP.
        n = pkt.size();
        for (int i = 0; i < 7; i++) raw.push_back(1'b0);
        raw.push_back(1'b1);
        for (int b = 0; b < n; b++)
            for (int i = 0; i < 8; i++) raw.push_back(pkt[b][i]);
        ones = 0;
        for (int r = 0; r < raw.size(); r++) begin
            stf.push_back(raw[r]);
            exp_r.push_back(1'b0);
            ones = raw[r] ? ones + 1 : 0;
            if (ones == 6) begin
                stf.push_back(1'b0);
                exp_r.push_back(1'b0);
                ones = 0;
            end
            if ((r % 8 == 7) && (r != raw.size() - 1)) exp_r[exp_r.size() - 1] = 1'b1;
        end
        lvl = 1'b0;
        foreach (stf[i]) begin
            if (!stf[i]) lvl = ~lvl;
            exp_d.push_back(lvl);
            exp_s.push_back(1'b0);
        end
        for (int i = 0; i < EOP; i++) begin
            exp_d.push_back(1'b0);
            exp_s.push_back(1'b1);
            exp_r.push_back(1'b0);
        end
        exp_d.push_back(1'b0);
        exp_s.push_back(1'b0);
        exp_r.push_back(1'b0);
        nsym = exp_d.size();

        valid = 1'b1;
        j = -1;
        k = 0;
        rdy_seen = 0;
        budget = 0;
        while (j < nsym) begin
            en_ph  = (en_ph + 1) % div;
            clk_en = (en_ph == 0);
            en_now = clk_en;
            // Garbage on data away from enabled cycles must never be taken.
            if (valid) data = (clk_en || div == 1) ? pkt[k] : 8'($urandom);
            else data = 8'($urandom);
            #1;
            rdy_now = ready;
            chk("ready", 32'(ready),
                32'(en_now && j >= 0 && j < nsym && exp_r[j]));
            @(posedge clk);
            #1;
            if (en_now) j++;
            if (rdy_now) begin
                rdy_seen++;
                k++;
                if (k >= n) valid = 1'b0;
            end
            if (j >= 0 && j < nsym) begin
                chk($sformatf("d_o[%0d]", j), 32'(d_o), 32'(exp_d[j]));
                chk($sformatf("se0[%0d]", j), 32'(se0), 32'(exp_s[j]));
                chk("oe_on", 32'(oe), 32'd1);
                chk("active_on", 32'(active), 32'd1);
            end else if (j == nsym) begin
                chk("oe_off", 32'(oe), 32'd0);
                chk("active_off", 32'(active), 32'd0);
                chk("d_o_idle", 32'(d_o), 32'd0);
                chk("se0_idle", 32'(se0), 32'd0);
            end
            if (en_now && j == abort_at) begin
                valid = 1'b0;
                #2;
                reset = 1'b0;
                #1;
                chk("abort_oe", 32'(oe), 32'd0);
                chk("abort_se0", 32'(se0), 32'd0);
                chk("abort_d_o", 32'(d_o), 32'd0);
                chk("abort_active", 32'(active), 32'd0);
                chk("abort_ready", 32'(ready), 32'd0);
                @(posedge clk);
                #1;
                reset = 1'b1;
                return;
            end
            budget++;
            if (budget > 4 * (nsym + 8)) begin
                chk("budget", 32'(j), 32'(nsym));
                valid = 1'b0;
                return;
            end
        end
        chk("ready_count", 32'(rdy_seen), 32'(n));
        // A few idle bit periods between packets.
        clk_en = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("gap_oe", 32'(oe), 32'd0);
        clk_en = 1'b0;
    endtask

    initial begin
        reset  = 1'b0;
        clk_en = 1'b0;
        valid  = 1'b0;
        data   = 8'h00;
        #12;
        chk("rst_oe", 32'(oe), 32'd0);
        chk("rst_se0", 32'(se0), 32'd0);
        chk("rst_d_o", 32'(d_o), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        pkt = '{8'h00};              send(1, -1);
        pkt = '{8'hFF};              send(1, -1);
        pkt = '{8'hC3, 8'hA5, 8'h5A}; send(1, -1);
        pkt = '{8'h7F};              send(1, -1);
        pkt = '{8'hFC};              send(1, -1);
        pkt = '{8'hFC, 8'h3F};       send(1, -1);
        pkt = '{8'h00};              send(1, 10);
        pkt = '{8'hA5};              send(1, -1);
        pkt = '{8'hC3, 8'hA5, 8'h5A}; send(4, -1);
        pkt = '{8'hFF, 8'hFC};       send(4, -1);

        for (int t = 0; t < 20; t++) begin
            int len;
            len = int'($urandom_range(1, 4));
            pkt.delete();
            for (int i = 0; i < len; i++) begin
                // Bias toward long runs of ones to exercise stuffing.
                if ($urandom_range(0, 2) == 0) pkt.push_back(8'hFF);
                else pkt.push_back(8'($urandom));
            end
            send(int'($urandom_range(1, 4)), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
